// File: rtl/ps2_pkg.sv
// Shared constants, entry layout and frame checking for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
    localparam int unsigned EXT_BIT        = 9;
    localparam int unsigned BRK_BIT        = 8;
    localparam int unsigned ENTRY_W        = 10;

    typedef enum logic [1:0] {
        FrmGood,
        FrmBadFraming,
        FrmBadParity
    } frame_status_e;

    // Frame bit 0 is start, 1..8 data LSB first, 9 odd parity, 10 stop.
    function automatic frame_status_e check_frame(input logic [PS2_FRAME_BITS-1:0] f);
        if (f[0] || !f[PS2_FRAME_BITS-1]) return FrmBadFraming;
        if (!(^f[9:1])) return FrmBadParity;
        return FrmGood;
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Read port of the PS/2 receiver: show-ahead head entry with valid/ready and fill level.
interface ps2_keyboard_rx_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    import ps2_pkg::*;

    logic [ENTRY_W-1:0]          out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [$clog2(FIFO_DEPTH):0] level;

    modport master (output out_data, output out_valid, output level, input out_ready);
    modport slave  (input out_data, input out_valid, input level, output out_ready);

endinterface

// File: rtl/ps2_fifo.sv
// Show-ahead FIFO with drop-on-full; a push into a full FIFO succeeds only alongside a pop.
module ps2_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     dropped
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dropped = push & ~do_push;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Masked so the head reads as zero while empty, including straight out of reset.
    assign rdata = empty ? '0 : mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin synchronisers, frame capture with watchdog, prefix folding
// and a buffered valid/ready read port with sticky error flags.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter bit          DECODE         = 1'b1
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    ps2_keyboard_rx_if.master        rd,
    output logic                     overflow,
    output logic                     parity_err,
    output logic                     frame_err,
    input  logic                     err_clr
);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0]      clk_sync;
    logic [SYNC_STAGES-1:0]      data_sync;
    logic                        clk_hist;
    logic                        clk_s;
    logic                        data_s;
    logic                        sample;
    logic [3:0]                  count;
    logic [PS2_FRAME_BITS-2:0]   shreg;
    logic [WDOG_W-1:0]           wdog;
    logic                        timeout;
    logic                        frame_done;
    frame_status_e               status;
    logic [7:0]                  code;
    logic                        ext_pend;
    logic                        brk_pend;
    logic                        ext_d;
    logic                        brk_d;
    logic                        push;
    logic [ENTRY_W-1:0]          push_data;
    logic                        set_parity;
    logic                        set_frame;
    logic                        dropped;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    // Reset to the idle-high level so no falling edge can be seen right after reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_hist  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_hist  <= clk_s;
        end
    end

    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign data_s     = data_sync[SYNC_STAGES-1];
    assign sample     = clk_hist & ~clk_s;
    assign frame_done = sample && (count == 4'(PS2_FRAME_BITS - 1));
    assign timeout    = (count != '0) && !sample && (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign status     = check_frame({data_s, shreg});
    assign code       = shreg[8:1];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count <= '0;
            wdog  <= '0;
            shreg <= '0;
        end else if (sample) begin
            wdog <= '0;
            if (frame_done) begin
                count <= '0;
            end else begin
                shreg[count] <= data_s;
                count        <= count + 4'd1;
            end
        end else if (timeout || count == '0) begin
            count <= '0;
            wdog  <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end

    always_comb begin
        push       = 1'b0;
        push_data  = '0;
        ext_d      = ext_pend;
        brk_d      = brk_pend;
        set_parity = 1'b0;
        set_frame  = timeout;
        if (timeout) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
        if (frame_done) begin
            case (status)
                FrmGood: begin
                    if (DECODE && code == PS2_PREFIX_EXT) begin
                        ext_d = 1'b1;
                    end else if (DECODE && code == PS2_PREFIX_BRK) begin
                        brk_d = 1'b1;
                    end else begin
                        push               = 1'b1;
                        push_data[EXT_BIT] = ext_pend;
                        push_data[BRK_BIT] = brk_pend;
                        push_data[7:0]     = code;
                        ext_d              = 1'b0;
                        brk_d              = 1'b0;
                    end
                end
                FrmBadParity: begin
                    set_parity = 1'b1;
                    ext_d      = 1'b0;
                    brk_d      = 1'b0;
                end
                default: begin
                    set_frame = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end
            endcase
        end
    end

    // A same-cycle set wins over err_clr.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            ext_pend   <= ext_d;
            brk_pend   <= brk_d;
            overflow   <= dropped | (overflow & ~err_clr);
            parity_err <= set_parity | (parity_err & ~err_clr);
            frame_err  <= set_frame | (frame_err & ~err_clr);
        end
    end

    ps2_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .push    (push),
        .wdata   (push_data),
        .pop     (rd.out_ready),
        .rdata   (rd.out_data),
        .empty   (fifo_empty),
        .level   (fifo_level),
        .dropped (dropped)
    );

    assign rd.out_valid = ~fifo_empty;
    assign rd.level     = fifo_level;

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Parametrised PS/2 keyboard receiver: samples the device-driven ps2_clk/ps2_data pair, checks each 11-bit frame, optionally folds E0/F0 prefixes into flagged scan codes, and buffers results in a configurable-depth FIFO with a valid/ready read port. It sits between the board PS/2 pins and the keyboard consumer (display or scan-code-to-ASCII logic). It adds error reporting, an inactivity timeout and a fill-level output.

## Interface
- FIFO_DEPTH, 8: entries; power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops on ps2_clk and ps2_data; ≥2.
- TIMEOUT_CYCLES, 50000: clk cycles without a ps2_clk falling edge that abort a partial frame; ≥16.
- DECODE, 1: 1 = absorb E0/F0 prefixes into flags; 0 = raw byte stream.

- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- ps2_clk  in  1  PS/2 clock pin, asynchronous.
- ps2_data  in  1  PS/2 data pin, asynchronous.
- out_data  out  10  {ext, brk, code[7:0]} at FIFO head; show-ahead.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer pops the head when high with out_valid.
- level  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky: an entry was dropped because the FIFO was full.
- parity_err  out  1  sticky: frame failed odd parity.
- frame_err  out  1  sticky: bad start bit, bad stop bit, or timeout.
- err_clr  in  1  synchronous clear of overflow, parity_err and frame_err.

## Operation
- Both pins pass through SYNC_STAGES flops, then one history flop. sample = hist & ~sync_out (falling edge). ps2_data is taken from the same stage as ps2_clk.
- Bit counter runs 0..10. On each sample, data bit is stored at index count and count increments. On count==10, the frame is evaluated and count returns to 0.
- Frame evaluation:
  - Good frame: start=0, stop=1, XOR of data[7:0] and parity = 1.
  - Bad start or bad stop: set frame_err, nothing pushed.
  - Parity failure with good start/stop: set parity_err, nothing pushed.
  - Any bad frame clears ext_pend and brk_pend.
- DECODE=1, good byte:
  - E0: ext_pend ← 1, no push.
  - F0: brk_pend ← 1, no push.
  - Any other byte: push {ext_pend, brk_pend, byte}, then clear both flags.
- DECODE=0: push {2'b00, byte} for every good byte. Prefix bytes are pushed as data.
- Timeout:
  - Watchdog counts clk cycles while count≠0 and restarts on every sample.
  - Reaching TIMEOUT_CYCLES sets count←0 and frame_err←1 and clears the pending flags.
  - Idle line (count==0) never times out.
- FIFO rules:
  - Push when full: entry dropped, overflow←1, contents unchanged.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH. level tracks occupancy exactly.
- err_clr has priority below a same-cycle set: the flag stays 1.
- Reset: count, watchdog, pointers and pending flags go to 0. All outputs are 0 (out_data 10'h000, out_valid 0, level 0, all flags 0). The synchroniser and history flops reset to 1 (idle-high line), so a spurious edge after reset is not possible. Reset mid-frame discards the partial frame.

## Timing
- Synchroniser latency from a pin change to sync_out: SYNC_STAGES cycles. sample asserts for exactly one cycle per falling edge.
- Stop-bit sample in cycle T:
  - Push and flag updates are registered at the edge ending T.
  - out_valid and level change at T+1.
  - out_data is valid in the same cycle as out_valid.
- Pop: head advances and level decrements at the clk edge where out_valid & out_ready. out_data shows the next entry the following cycle.
- Sticky flags rise one cycle after the triggering sample or timeout.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last sample.
- Throughput is limited by the PS/2 clock (≥ ~60 µs per bit) only. The FIFO accepts one push and one pop per cycle.

## Structure
- Package ps2_pkg:
  - PS2_FRAME_BITS = 11
  - PS2_PREFIX_EXT = 8'hE0
  - PS2_PREFIX_BRK = 8'hF0
  - entry layout (EXT_BIT = 9, BRK_BIT = 8)
- Sub-module ps2_fifo (WIDTH, DEPTH):
  - synchronous show-ahead FIFO with push/pop/full/empty/level
  - drop-on-full, with a dropped pulse feeding overflow
- Top level holds the synchronisers, edge detect, bit counter, watchdog and prefix decoder.

## Test plan
- Reset, then send good frame 0x1C (A make) → out_valid at stop-sample+1, out_data 10'h01C, level 1. Pop → out_valid 0, level 0.
- DECODE=1, send E0 F0 75 → one entry 10'h375 (ext=1, brk=1). DECODE=0, same bytes → three entries 0x0E0, 0x0F0, 0x075.
- Frame 0x1C with flipped parity bit → no push, parity_err=1. err_clr pulse → parity_err=0. Stop bit 0 → frame_err=1.
- Send 6 bits, then hold ps2_clk high for TIMEOUT_CYCLES → frame_err=1 at exactly TIMEOUT_CYCLES after the last sample. Next full frame 0x29 → decoded correctly.
- FIFO_DEPTH=4, out_ready=0, send 5 codes 0x16,0x1E,0x26,0x25,0x2E → level 4, overflow=1. Drain yields 0x16,0x1E,0x26,0x25. Push coinciding with a pop on a full FIFO → no overflow.
- Assert clrn low mid-frame (after bit 5) → all outputs 0. After release, a full frame 0x45 → single correct entry, no error flags.
